imm_gen_queue: RTL
==================

# imm_gen_queue

Parametrised immediate/offset decode stage with a built-in instruction queue, sitting between fetch and execute. Each accepted instruction is decoded into `imm`, `offset`, format code and PC-relative target at XLEN width, then buffered in a DEPTH-entry FIFO. Valid/ready handshakes decouple fetch from execute.

## Interface
- `XLEN`, default 32: datapath width; legal values are 32 and 64.
- `DEPTH`, default 2: FIFO entries; must be a power of 2 and ≥2.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous queue clear
- `in_valid`  in  1  upstream instruction valid
- `in_ready`  out  1  queue can accept
- `in_instr`  in  32  RV instruction word
- `in_pc`  in  XLEN  instruction address
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream consumes head
- `out_imm`  out  XLEN  ALU immediate
- `out_offset`  out  XLEN  address offset
- `out_target`  out  XLEN  pc + offset for PC-relative formats, else 0
- `out_fmt`  out  3  format code
- `out_illegal`  out  1  unrecognised opcode
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Decode is combinational on `in_instr`/`in_pc`; the result is written to the FIFO tail on a push. sext/zext are to XLEN.
- Unlisted result fields are 0.
- 0110111 LUI: fmt 1; imm = sext({i[31:12],12'b0}).
- 0010111 AUIPC: fmt 2; offset = sext({i[31:12],12'b0}); target = pc+offset.
- 1101111 JAL: fmt 3; offset = sext({i[31],i[19:12],i[20],i[30:21],1'b0}); target = pc+offset.
- 1100111 JALR: fmt 4; offset = sext(i[31:20]); target 0 (needs rs1).
- 1100011 branch: fmt 5; offset = sext({i[31],i[7],i[30:25],i[11:8],1'b0}) for all funct3, including unsigned compares; target = pc+offset.
- 0000011 load / 0100011 store: fmt 6.
  - Load: offset = sext(i[31:20]).
  - Store: offset = sext({i[31:25],i[11:7]}).
- 0010011 OP-IMM: fmt 7.
  - funct3 001/101: imm = zext(shamt). Shamt is i[24:20] for XLEN=32 and i[25:20] for XLEN=64.
  - Other funct3: imm = sext(i[31:20]).
- Any other opcode: fmt 0, all fields 0, illegal per Configuration.
- Target addition wraps modulo 2^XLEN.
- Push = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- `in_ready` = (count < DEPTH) & !flush. It does not depend on `out_ready`; there is no full-queue pass-through.
- `out_valid` = (count != 0). Data outputs are driven from the head entry and masked to 0 while `out_valid`=0.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Pointers wrap at DEPTH.
- `flush`: next edge sets count and pointers to 0. Any pop that cycle is discarded. `in_ready` is 0 during flush, so no push occurs.

## Timing
- Reset (async assert, sync release):
  - count=0, pointers=0.
  - out_valid=0; all data outputs 0.
  - in_ready=1 once rst_n is high (count=0).
  - Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Latency: an instruction pushed at edge N appears with `out_valid`=1 in the cycle after N, i.e. 1 cycle through an empty queue.
- Throughput: 1 instruction/cycle sustained when `out_ready`=1.
- Full (count=DEPTH): in_ready=0 until the edge after a pop.
- Head outputs are stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- `IMM_GEN_ILLEGAL_EN` defined:
  - Unknown opcodes push with out_illegal=1 and fmt 0.
  - The illegal bit is stored per entry.
- Undefined:
  - out_illegal is tied to 0 and no storage bit exists.
  - Unknown opcodes still push with fmt 0 and zero fields.

## Test plan
- XLEN=32, push 0x12345037, pc 0x0 -> next cycle: out_valid=1, imm 0x12345000, fmt 1, offset 0, target 0.
- Push 0xFFDFF06F (jal x0,-4), pc 0x100 -> offset 0xFFFFFFFC, target 0x000000FC, fmt 3. Push 0xFE006EE3 (bltu,-4), pc 0x200 -> offset 0xFFFFFFFC, target 0x1FC, fmt 5.
- Push 0x4030D093 (srai 3) -> imm 3. Push 0xFFF00093 (addi -1) -> imm 0xFFFFFFFF. With XLEN=64, the addi gives imm 0xFFFFFFFFFFFFFFFF.
- DEPTH=2, out_ready=0, three back-to-back pushes -> in_ready=0 after the 2nd, count=2, 3rd held. Then out_ready=1 -> entries pop in order, one per cycle, and the held push completes with count unchanged.
- Push 0x00000000 with `IMM_GEN_ILLEGAL_EN` -> out_illegal=1, fmt 0, all fields 0. Without the macro -> out_illegal=0.
- count=2, then pulse flush -> count=0 and out_valid=0 next cycle, in_ready=0 during flush. Separately, drop rst_n mid-stream -> out_valid=0 and count=0 without a clock edge.

Source files
------------

// File: rtl/imm_gen_queue.sv
// imm_gen_queue: RV immediate/offset decode feeding a DEPTH-entry FIFO.
// Fetch pushes raw instructions; each is decoded on the way in. Execute pops
// decoded imm/offset/target/format entries from the head.
// Optional feature macro: IMM_GEN_ILLEGAL_EN stores a per-entry illegal-opcode
// flag; without it out_illegal is tied low and no flag storage exists.

module imm_gen_queue #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [XLEN-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [XLEN-1:0]          out_imm,
   output logic [XLEN-1:0]          out_offset,
   output logic [XLEN-1:0]          out_target,
   output logic [2:0]               out_fmt,
   output logic                     out_illegal,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   // Sign-extend a 32-bit pattern to the datapath width.
   function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
      return XLEN'(signed'(v));
   endfunction

   // Zero-extend a 32-bit pattern to the datapath width.
   function automatic logic [XLEN-1:0] zext(input logic [31:0] v);
      return XLEN'(v);
   endfunction

   logic [31:0] u_val;
   logic [31:0] j_val;
   logic [31:0] b_val;
   logic [31:0] i_val;
   logic [31:0] s_val;
   logic [31:0] sh_val;

   // Raw immediate layouts for every format, already widened to 32 bits.
   assign u_val  = {in_instr[31:12], 12'b0};
   assign j_val  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign b_val  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign i_val  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign s_val  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign sh_val = (XLEN == 64) ? {26'b0, in_instr[25:20]} : {27'b0, in_instr[24:20]};

   logic [XLEN-1:0] dec_imm;
   logic [XLEN-1:0] dec_offset;
   logic [XLEN-1:0] dec_target;
   logic [2:0]      dec_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
   logic            dec_illegal;
`endif

   // Opcode-driven decode of the incoming instruction; unlisted fields stay 0.
   always_comb begin
      dec_imm    = '0;
      dec_offset = '0;
      dec_target = '0;
      dec_fmt    = 3'd0;
`ifdef IMM_GEN_ILLEGAL_EN
      dec_illegal = 1'b0;
`endif
      case (in_instr[6:0])
         7'b0110111: begin
            dec_fmt = 3'd1;
            dec_imm = sext(u_val);
         end
         7'b0010111: begin
            dec_fmt    = 3'd2;
            dec_offset = sext(u_val);
            dec_target = in_pc + sext(u_val);
         end
         7'b1101111: begin
            dec_fmt    = 3'd3;
            dec_offset = sext(j_val);
            dec_target = in_pc + sext(j_val);
         end
         7'b1100111: begin
            dec_fmt    = 3'd4;
            dec_offset = sext(i_val);
         end
         7'b1100011: begin
            dec_fmt    = 3'd5;
            dec_offset = sext(b_val);
            dec_target = in_pc + sext(b_val);
         end
         7'b0000011: begin
            dec_fmt    = 3'd6;
            dec_offset = sext(i_val);
         end
         7'b0100011: begin
            dec_fmt    = 3'd6;
            dec_offset = sext(s_val);
         end
         7'b0010011: begin
            dec_fmt = 3'd7;
            if (in_instr[13:12] == 2'b01)
               dec_imm = zext(sh_val);
            else
               dec_imm = sext(i_val);
         end
         default: begin
`ifdef IMM_GEN_ILLEGAL_EN
            dec_illegal = 1'b1;
`endif
         end
      endcase
   end

   logic [XLEN-1:0] imm_mem    [DEPTH];
   logic [XLEN-1:0] offset_mem [DEPTH];
   logic [XLEN-1:0] target_mem [DEPTH];
   logic [2:0]      fmt_mem    [DEPTH];
`ifdef IMM_GEN_ILLEGAL_EN
   logic            ill_mem    [DEPTH];
`endif

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   assign in_ready  = (count < FULL) & ~flush;
   assign out_valid = (count != '0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   // Payload storage; no reset needed because outputs are masked when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         imm_mem[wr_ptr]    <= dec_imm;
         offset_mem[wr_ptr] <= dec_offset;
         target_mem[wr_ptr] <= dec_target;
         fmt_mem[wr_ptr]    <= dec_fmt;
`ifdef IMM_GEN_ILLEGAL_EN
         ill_mem[wr_ptr]    <= dec_illegal;
`endif
      end
   end

   // Pointer and occupancy bookkeeping; flush discards everything including a same-cycle pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   assign out_imm    = out_valid ? imm_mem[rd_ptr]    : '0;
   assign out_offset = out_valid ? offset_mem[rd_ptr] : '0;
   assign out_target = out_valid ? target_mem[rd_ptr] : '0;
   assign out_fmt    = out_valid ? fmt_mem[rd_ptr]    : 3'd0;
`ifdef IMM_GEN_ILLEGAL_EN
   assign out_illegal = out_valid & ill_mem[rd_ptr];
`else
   assign out_illegal = 1'b0;
`endif

endmodule
